// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: hazard inputs from the ID/EX
// stages and the stall/flush/bubble controls plus statistics counters.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_rs1_i;
    logic [4:0]       IFID_rs2_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_rd_i;
    logic             Predict_taken_i;
    logic             Mispredict_i;
    logic             Mem_stall_i;
    logic             Cnt_clr_i;
    logic             Stall_o;
    logic             Flush_o;
    logic             Flush_EX_o;
    logic             PCWrite_o;
    logic             NoOp_o;
    logic             PCSel_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport slave (
        input  IFID_rs1_i, IFID_rs2_i, IDEX_MemRead_i, IDEX_rd_i,
               Predict_taken_i, Mispredict_i, Mem_stall_i, Cnt_clr_i,
        output Stall_o, Flush_o, Flush_EX_o, PCWrite_o, NoOp_o, PCSel_o,
               stall_cnt_o, flush_cnt_o
    );

    modport master (
        output IFID_rs1_i, IFID_rs2_i, IDEX_MemRead_i, IDEX_rd_i,
               Predict_taken_i, Mispredict_i, Mem_stall_i, Cnt_clr_i,
        input  Stall_o, Flush_o, Flush_EX_o, PCWrite_o, NoOp_o, PCSel_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, mispredict/predict-taken flushes,
// memory-stall freeze with a held mispredict, and saturating statistics counters.
//
// state    | meaning
// RUN      | pipeline advancing normally
// MEM_WAIT | data memory busy, whole pipeline frozen
module hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter bit IGNORE_X0 = 1'b1
) (
    input  logic          clk_i,
    input  logic          start_i,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state_q;
    logic             pend_q;
    logic             pend_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic mis_eff;
    logic load_use;
    logic stall;
    logic flush;
    logic flush_ex;
    logic pc_write;
    logic no_op;
    logic pc_sel;

    assign mis_eff  = bus.Mispredict_i | pend_q;
    assign load_use = bus.IDEX_MemRead_i
                      && ((bus.IDEX_rd_i == bus.IFID_rs1_i) || (bus.IDEX_rd_i == bus.IFID_rs2_i))
                      && !(IGNORE_X0 && (bus.IDEX_rd_i == 5'd0));

    always_comb begin
        stall    = 1'b0;
        flush    = 1'b0;
        flush_ex = 1'b0;
        pc_write = 1'b1;
        no_op    = 1'b0;
        pc_sel   = 1'b0;
        if (bus.Mem_stall_i) begin
            stall    = 1'b1;
            pc_write = 1'b0;
        end else if (mis_eff) begin
            flush    = 1'b1;
            flush_ex = 1'b1;
            pc_sel   = 1'b1;
        end else if (load_use) begin
            stall    = 1'b1;
            pc_write = 1'b0;
            no_op    = 1'b1;
        end else if (bus.Predict_taken_i) begin
            flush    = 1'b1;
        end
    end

    // A mispredict seen during a freeze is held until the first unfrozen cycle.
    always_comb begin
        pend_d = pend_q;
        if (bus.Mem_stall_i) begin
            pend_d = pend_q | bus.Mispredict_i;
        end else if (mis_eff) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q     <= RUN;
            pend_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN:      if (bus.Mem_stall_i)  state_q <= MEM_WAIT;
                MEM_WAIT: if (!bus.Mem_stall_i) state_q <= RUN;
                default:  state_q <= RUN;
            endcase
            pend_q <= pend_d;
            if (bus.Cnt_clr_i) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (stall && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + 1'b1;
                if (flush_ex && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.Stall_o     = stall;
    assign bus.Flush_o     = flush;
    assign bus.Flush_EX_o  = flush_ex;
    assign bus.PCWrite_o   = pc_write;
    assign bus.NoOp_o      = no_op;
    assign bus.PCSel_o     = pc_sel;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized cycles
// checked against a behavioural model of the hazard priority rules.
module tb_hazard_ctrl;
    localparam int CW  = 4;
    localparam int SAT = 15;

    // control vector packing: {Stall, Flush, Flush_EX, PCWrite, NoOp, PCSel}
    localparam logic [5:0] C_IDLE = 6'b000100;
    localparam logic [5:0] C_MEM  = 6'b100000;
    localparam logic [5:0] C_MIS  = 6'b011101;
    localparam logic [5:0] C_LU   = 6'b100010;
    localparam logic [5:0] C_PT   = 6'b010100;

    logic clk = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus();
    hazard_ctrl #(.CNT_W(CW), .IGNORE_X0(1'b1)) dut (
        .clk_i   (clk),
        .start_i (start),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    bit m_pend = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    logic [5:0] ctrl;
    assign ctrl = {bus.Stall_o, bus.Flush_o, bus.Flush_EX_o, bus.PCWrite_o, bus.NoOp_o, bus.PCSel_o};

    function automatic logic [5:0] model_ctrl();
        bit lu;
        lu = bus.IDEX_MemRead_i && (bus.IDEX_rd_i != 0)
             && (bus.IDEX_rd_i == bus.IFID_rs1_i || bus.IDEX_rd_i == bus.IFID_rs2_i);
        if (bus.Mem_stall_i)                 return C_MEM;
        if (bus.Mispredict_i || m_pend)      return C_MIS;
        if (lu)                              return C_LU;
        if (bus.Predict_taken_i)             return C_PT;
        return C_IDLE;
    endfunction

    task automatic drive(input int rs1, input int rs2, input bit mr, input int rd,
                         input bit pt, input bit mis, input bit ms, input bit clr);
        bus.IFID_rs1_i      = 5'(rs1);
        bus.IFID_rs2_i      = 5'(rs2);
        bus.IDEX_MemRead_i  = mr;
        bus.IDEX_rd_i       = 5'(rd);
        bus.Predict_taken_i = pt;
        bus.Mispredict_i    = mis;
        bus.Mem_stall_i     = ms;
        bus.Cnt_clr_i       = clr;
    endtask

    task automatic idle();
        drive(1, 2, 0, 3, 0, 0, 0, 0);
    endtask

    // Advance one clock; the model updates from the inputs held across the edge.
    task automatic tick();
        logic [5:0] e;
        @(posedge clk);
        if (start) begin
            e = model_ctrl();
            if (bus.Cnt_clr_i) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (e[5] && m_stall < SAT) m_stall++;
                if (e[3] && m_flush < SAT) m_flush++;
            end
            if (bus.Mem_stall_i) m_pend = m_pend | bus.Mispredict_i;
            else if (e[3])       m_pend = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic clear_counters();
        drive(1, 2, 0, 3, 0, 0, 0, 1);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        #1;
        total++;
        if (ctrl !== C_IDLE || bus.stall_cnt_o !== 4'd0 || bus.flush_cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: ctrl=%b stall_cnt=%0d flush_cnt=%0d want ctrl=%b cnt=0/0",
                     ctrl, bus.stall_cnt_o, bus.flush_cnt_o, C_IDLE);
        end
        @(negedge clk);
        start = 1'b1;
        // build up a pending mispredict and some counts, then reset mid-stall
        drive(1, 2, 0, 3, 0, 1, 1, 0);
        tick();
        drive(1, 2, 0, 3, 0, 0, 1, 0);
        #2;
        start   = 1'b0;
        m_pend  = 1'b0;
        m_stall = 0;
        m_flush = 0;
        #1;
        total++;
        if (bus.stall_cnt_o !== 4'd0 || bus.flush_cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid_counters: stall_cnt=%0d flush_cnt=%0d want 0/0",
                     bus.stall_cnt_o, bus.flush_cnt_o);
        end
        idle();
        #1;
        total++;
        if (ctrl !== C_IDLE) begin
            bad++;
            $display("FAIL reset_drops_pending: ctrl=%b want %b", ctrl, C_IDLE);
        end
        @(negedge clk);
        start = 1'b1;
        tick();
        total++;
        if (ctrl !== C_IDLE || bus.flush_cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_after_release: ctrl=%b flush_cnt=%0d want %b/0",
                     ctrl, bus.flush_cnt_o, C_IDLE);
        end
    endtask

    task automatic test_load_use();
        clear_counters();
        drive(1, 5, 1, 5, 0, 0, 0, 0);
        #1;
        total++;
        if (ctrl !== C_LU) begin
            bad++;
            $display("FAIL load_use_ctrl: ctrl=%b want %b", ctrl, C_LU);
        end
        tick();
        idle();
        #1;
        total++;
        if (ctrl !== C_IDLE || bus.stall_cnt_o !== 4'd1) begin
            bad++;
            $display("FAIL load_use_one_cycle: ctrl=%b stall_cnt=%0d want %b/1",
                     ctrl, bus.stall_cnt_o, C_IDLE);
        end
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (ctrl !== C_IDLE) begin
            bad++;
            $display("FAIL load_use_x0: ctrl=%b want %b", ctrl, C_IDLE);
        end
        tick();
        total++;
        if (bus.stall_cnt_o !== 4'd1) begin
            bad++;
            $display("FAIL load_use_x0_cnt: stall_cnt=%0d want 1", bus.stall_cnt_o);
        end
    endtask

    task automatic test_mispredict_priority();
        clear_counters();
        drive(5, 5, 1, 5, 1, 1, 0, 0);
        #1;
        total++;
        if (ctrl !== C_MIS) begin
            bad++;
            $display("FAIL mis_priority_ctrl: ctrl=%b want %b", ctrl, C_MIS);
        end
        tick();
        idle();
        #1;
        total++;
        if (ctrl !== C_IDLE || bus.flush_cnt_o !== 4'd1 || bus.stall_cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL mis_priority_cnt: ctrl=%b flush_cnt=%0d stall_cnt=%0d want %b/1/0",
                     ctrl, bus.flush_cnt_o, bus.stall_cnt_o, C_IDLE);
        end
    endtask

    task automatic test_mem_stall_pending();
        clear_counters();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 0, 3, 0, (i == 1), 1, 0);
            #1;
            total++;
            if (ctrl !== C_MEM) begin
                bad++;
                $display("FAIL mem_stall_cycle%0d: ctrl=%b want %b", i, ctrl, C_MEM);
            end
            tick();
        end
        idle();
        #1;
        total++;
        if (ctrl !== C_MIS) begin
            bad++;
            $display("FAIL mem_stall_release_flush: ctrl=%b want %b", ctrl, C_MIS);
        end
        tick();
        total++;
        if (ctrl !== C_IDLE || bus.flush_cnt_o !== 4'd1 || bus.stall_cnt_o !== 4'd3) begin
            bad++;
            $display("FAIL mem_stall_after: ctrl=%b flush_cnt=%0d stall_cnt=%0d want %b/1/3",
                     ctrl, bus.flush_cnt_o, bus.stall_cnt_o, C_IDLE);
        end
    endtask

    task automatic test_predict_taken();
        clear_counters();
        drive(1, 2, 0, 3, 1, 0, 0, 0);
        #1;
        total++;
        if (ctrl !== C_PT) begin
            bad++;
            $display("FAIL predict_taken_ctrl: ctrl=%b want %b", ctrl, C_PT);
        end
        tick();
        idle();
        #1;
        total++;
        if (bus.flush_cnt_o !== 4'd0 || bus.stall_cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL predict_taken_cnt: flush_cnt=%0d stall_cnt=%0d want 0/0",
                     bus.flush_cnt_o, bus.stall_cnt_o);
        end
    endtask

    task automatic test_saturation();
        clear_counters();
        for (int i = 0; i < 20; i++) begin
            drive(5, 7, 1, 5, 0, 0, 0, 0);
            #1;
            total++;
            if (bus.stall_cnt_o !== 4'((i < SAT) ? i : SAT)) begin
                bad++;
                $display("FAIL sat_count_%0d: stall_cnt=%0d want %0d", i, bus.stall_cnt_o,
                         (i < SAT) ? i : SAT);
            end
            tick();
        end
        total++;
        if (bus.stall_cnt_o !== 4'd15) begin
            bad++;
            $display("FAIL sat_hold: stall_cnt=%0d want 15", bus.stall_cnt_o);
        end
        drive(5, 7, 1, 5, 0, 0, 0, 1);
        #1;
        total++;
        if (ctrl !== C_LU) begin
            bad++;
            $display("FAIL sat_clr_ctrl: ctrl=%b want %b", ctrl, C_LU);
        end
        tick();
        idle();
        #1;
        total++;
        if (bus.stall_cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL sat_clr_priority: stall_cnt=%0d want 0", bus.stall_cnt_o);
        end
    endtask

    task automatic test_random();
        logic [5:0] e;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3), $urandom_range(3), ($urandom_range(99) < 50),
                  $urandom_range(3), ($urandom_range(99) < 30), ($urandom_range(99) < 15),
                  ($urandom_range(99) < 25), ($urandom_range(99) < 3));
            #1;
            e = model_ctrl();
            total++;
            if (ctrl !== e || bus.stall_cnt_o !== 4'(m_stall) || bus.flush_cnt_o !== 4'(m_flush)) begin
                bad++;
                $display("FAIL random_%0d: ctrl=%b cnt=%0d/%0d want ctrl=%b cnt=%0d/%0d", i,
                         ctrl, bus.stall_cnt_o, bus.flush_cnt_o, e, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mispredict_priority();
        test_mem_stall_pending();
        test_predict_taken();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller; the producer of the stall and flush controls consumed by the IFID pipeline register (Stall_i, Flush_i, Flush_EX_i) and of the PC-write enable and bubble-insert controls.
- Detects load-use hazards, branch mispredicts, predict-taken redirects and data-memory stalls; holds a mispredict arriving during a memory stall until it can be issued.
- Keeps saturating statistics counters for stall cycles and mispredict flushes.

Parameters:
- CNT_W, 16, width of each statistics counter.
- IGNORE_X0, 1, when 1 a load whose rd is x0 never causes a load-use stall.

Ports:
- clk_i  input  1  clock, rising edge.
- start_i  input  1  reset, asynchronous, active-low.
- IFID_rs1_i  input  5  rs1 field of the instruction in ID.
- IFID_rs2_i  input  5  rs2 field of the instruction in ID.
- IDEX_MemRead_i  input  1  instruction in EX is a load.
- IDEX_rd_i  input  5  destination register of the instruction in EX.
- Predict_taken_i  input  1  branch in ID is predicted taken.
- Mispredict_i  input  1  single-cycle pulse: the branch resolved in EX was mispredicted.
- Mem_stall_i  input  1  data memory busy; the whole pipeline must freeze.
- Cnt_clr_i  input  1  synchronous clear of both counters.
- Stall_o  output  1  to IFID Stall_i.
- Flush_o  output  1  to IFID Flush_i.
- Flush_EX_o  output  1  to IFID Flush_EX_i and the ID/EX flush.
- PCWrite_o  output  1  PC register write enable.
- NoOp_o  output  1  insert a bubble into ID/EX.
- PCSel_o  output  1  select the corrected branch PC.
- stall_cnt_o  output  CNT_W  number of cycles with Stall_o=1.
- flush_cnt_o  output  CNT_W  number of mispredict flushes issued.

Behaviour:
- Reset (start_i=0, asynchronous):
  - State goes to RUN, pend_q=0, both counters 0.
  - Outputs are then Stall_o=0, Flush_o=0, Flush_EX_o=0, NoOp_o=0, PCSel_o=0, PCWrite_o=1.
  - Reset mid-stall discards any pending mispredict.
- State register, 2 states:
  - RUN -> MEM_WAIT on a rising edge with Mem_stall_i=1.
  - MEM_WAIT -> RUN on a rising edge with Mem_stall_i=0.
- pend_q:
  - Set on an edge where Mispredict_i=1 and Mem_stall_i=1.
  - Cleared on the edge that issues the flush.
- Control outputs are combinational from inputs and registered state, evaluated in this priority order:
  1. Mem_stall_i=1: Stall_o=1, PCWrite_o=0; all flush outputs, NoOp_o and PCSel_o are 0.
  2. mis_eff = Mispredict_i | pend_q: Flush_o=1, Flush_EX_o=1, PCSel_o=1, PCWrite_o=1, Stall_o=0, NoOp_o=0. Load-use and Predict_taken_i are ignored, because those instructions are being flushed.
  3. Load-use, defined as IDEX_MemRead_i=1 and (IDEX_rd_i==IFID_rs1_i or IDEX_rd_i==IFID_rs2_i), excluding IDEX_rd_i==0 when IGNORE_X0=1: Stall_o=1, PCWrite_o=0, NoOp_o=1, Flush_o=0. Predict_taken_i is ignored; the branch re-presents next cycle.
  4. Predict_taken_i=1: Flush_o=1, PCWrite_o=1; all others 0.
  5. Otherwise: all outputs 0 except PCWrite_o=1.
- Latency: zero-cycle; controls are valid in the same cycle as their cause and are sampled by the pipeline registers at the next edge.
- Load-use stall length: exactly 1 cycle; after the bubble, IDEX_MemRead_i drops and the hazard clears.
- A Mispredict_i pulse and pend_q both set in the same cycle produce one flush, counted once.
- Counters:
  - stall_cnt increments each edge where Stall_o=1.
  - flush_cnt increments each edge where Flush_EX_o=1.
  - Both saturate at all-ones and do not wrap.
  - Cnt_clr_i=1 zeroes both counters; clear takes priority over increment in the same cycle.
- Stated timing is exact; there are no X outputs after reset.

Test Plan:
- Reset: drive start_i low mid-cycle -> outputs reach reset values immediately; counters=0; pend_q=0; PCWrite_o=1.
- Load-use: IDEX_MemRead_i=1, IDEX_rd_i=5, IFID_rs2_i=5 for 1 cycle -> Stall_o=1, NoOp_o=1, PCWrite_o=0 for 1 cycle; stall_cnt=1. The same with rd=0 and IGNORE_X0=1 -> no stall.
- Mispredict plus load-use plus Predict_taken in the same cycle -> Flush_o=1, Flush_EX_o=1, PCSel_o=1, Stall_o=0; flush_cnt=1.
- Mem_stall_i high for 3 cycles with a Mispredict_i pulse in the 2nd cycle -> Stall_o=1 for 3 cycles with no flush; the flush is issued in exactly the first cycle after Mem_stall_i falls; flush_cnt=1; stall_cnt=3.
- Predict_taken_i=1 alone -> Flush_o=1, Flush_EX_o=0, PCWrite_o=1; counters unchanged.
- Saturation with CNT_W=4: 20 consecutive load-use cycles -> stall_cnt=15 and holds. Then Cnt_clr_i=1 with Stall_o=1 -> stall_cnt=0.
